// File: rtl/sp_ram_pkg.sv
// Shared constants for the byte-write single-port RAM:
// write-mode encodings and clear-sequencer states.
package sp_ram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/sp_ram_clear_seq.sv
// Memory-clear sequencer: walks every address once after reset,
// holding busy until the last word has been written.
module sp_ram_clear_seq
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  logic [0:0]      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/sp_ram_bytewrite.sv
// Single-port synchronous RAM with byte enables, selectable
// write mode, optional output register and hardware clear.
module sp_ram_bytewrite
  import sp_ram_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 8,
  parameter int                BYTE_W       = 8,
  parameter int                WRITE_MODE   = 0,
  parameter int                OUT_REG      = 0,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL    = '0
) (
  input  logic                       clka,
  input  logic                       rsta,
  input  logic                       ena,
  input  logic [DATA_W/BYTE_W-1:0]   wea,
  input  logic [ADDR_W-1:0]          addra,
  input  logic [DATA_W-1:0]          dina,
  output logic [DATA_W-1:0]          douta,
  output logic                       valida,
  output logic                       busya
);

  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("DATA_W must be an integer multiple of BYTE_W");
  end

  logic              busy, clr_we;
  logic [ADDR_W-1:0] clr_addr;

  sp_ram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .CLEAR_ON_RST(CLEAR_ON_RST)
  ) u_clr (
    .clk     (clka),
    .rst     (rsta),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc, wr_clr;
  logic [DATA_W-1:0] rd_old, rd_mrg;

  assign acc    = ena & ~busy & ~rsta;
  assign wr_clr = clr_we & ~rsta;
  assign busya  = busy;

  always_comb begin
    rd_old = mem[addra];
    rd_mrg = rd_old;
    for (int i = 0; i < NB; i++) begin
      if (wea[i]) rd_mrg[i*BYTE_W +: BYTE_W] = dina[i*BYTE_W +: BYTE_W];
    end
  end

  always_ff @(posedge clka) begin
    if (wr_clr) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i])
          mem[addra][i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
      end
    end
  end

  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_vld_q, s1_vld_d;

  // NO_CHANGE writes leave the read register untouched
  always_comb begin
    s1_data_d = s1_data_q;
    s1_vld_d  = 1'b0;
    if (acc) begin
      if (WRITE_MODE == WM_WRITE_FIRST) begin
        s1_data_d = rd_mrg;
        s1_vld_d  = 1'b1;
      end else if (WRITE_MODE == WM_NO_CHANGE && |wea) begin
        s1_vld_d  = 1'b0;
      end else begin
        s1_data_d = rd_old;
        s1_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      s1_data_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_data_q <= s1_data_d;
      s1_vld_q  <= s1_vld_d;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              s2_vld_q;

    assign s2_data_d = s1_vld_q ? s1_data_q : s2_data_q;

    always_ff @(posedge clka) begin
      if (rsta) begin
        s2_data_q <= '0;
        s2_vld_q  <= 1'b0;
      end else begin
        s2_data_q <= s2_data_d;
        s2_vld_q  <= s1_vld_q;
      end
    end

    assign douta  = s2_data_q;
    assign valida = s2_vld_q;
  end else begin : g_noreg
    assign douta  = s1_data_q;
    assign valida = s1_vld_q;
  end

endmodule

// File: tb/tb_sp_ram_bytewrite.sv
// Bench: three RAM variants share one stimulus stream and are
// checked against a scoreboard fed by a behavioural memory.
module tb_sp_ram_bytewrite;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [3:0]  we, addr;
  logic [31:0] din;
  logic [31:0] dout [3];
  logic        vld  [3];
  logic        bsy  [3];

  sp_ram_bytewrite #(
    .DATA_W(32), .ADDR_W(4), .BYTE_W(8),
    .WRITE_MODE(0), .OUT_REG(0),
    .CLEAR_ON_RST(1), .CLEAR_VAL(32'hDEADBEEF)
  ) u_rf (
    .clka(clk), .rsta(rst), .ena(en), .wea(we),
    .addra(addr), .dina(din), .douta(dout[0]),
    .valida(vld[0]), .busya(bsy[0])
  );

  sp_ram_bytewrite #(
    .DATA_W(32), .ADDR_W(4), .BYTE_W(8),
    .WRITE_MODE(1), .OUT_REG(1),
    .CLEAR_ON_RST(1), .CLEAR_VAL(32'hDEADBEEF)
  ) u_wf (
    .clka(clk), .rsta(rst), .ena(en), .wea(we),
    .addra(addr), .dina(din), .douta(dout[1]),
    .valida(vld[1]), .busya(bsy[1])
  );

  sp_ram_bytewrite #(
    .DATA_W(32), .ADDR_W(4), .BYTE_W(8),
    .WRITE_MODE(2), .OUT_REG(0),
    .CLEAR_ON_RST(1), .CLEAR_VAL(32'hDEADBEEF)
  ) u_nc (
    .clka(clk), .rsta(rst), .ena(en), .wea(we),
    .addra(addr), .dina(din), .douta(dout[2]),
    .valida(vld[2]), .busya(bsy[2])
  );

  typedef struct {
    int          cyc;
    logic [31:0] d;
  } exp_t;

  exp_t        q [3][$];
  logic [31:0] mdl  [16];
  logic [31:0] last [3];
  int          clr_left, cyc, bc;
  int          npass, nfail, ntot;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic        acc, ev;
    logic [31:0] old, mrg;
    exp_t        e;
    acc = en && clr_left == 0 && !rst;
    if (acc) begin
      old = mdl[addr];
      for (int i = 0; i < 4; i++)
        mrg[i*8 +: 8] = we[i] ? din[i*8 +: 8] : old[i*8 +: 8];
      q[0].push_back('{cyc + 1, old});
      q[1].push_back('{cyc + 2, mrg});
      if (we == 4'h0) q[2].push_back('{cyc + 1, old});
      mdl[addr] = mrg;
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      clr_left = 16;
      for (int a = 0; a < 16; a++) mdl[a] = 32'hDEADBEEF;
      for (int k = 0; k < 3; k++) begin
        q[k].delete();
        last[k] = '0;
      end
    end else if (clr_left > 0) begin
      clr_left--;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_busy@%0d", k, cyc),
          32'(bsy[k]), 32'(clr_left > 0));
      ev = q[k].size() > 0 && q[k][0].cyc == cyc;
      chk($sformatf("u%0d_valid@%0d", k, cyc),
          32'(vld[k]), 32'(ev));
      if (ev) begin
        e = q[k].pop_front();
        last[k] = e.d;
        chk($sformatf("u%0d_data@%0d", k, cyc), dout[k], e.d);
      end else begin
        chk($sformatf("u%0d_hold@%0d", k, cyc), dout[k], last[k]);
      end
    end
  endtask

  task automatic acc_op(logic e, logic [3:0] w,
                        logic [3:0] a, logic [31:0] d);
    en = e; we = w; addr = a; din = d;
    tick();
  endtask

  initial begin
    npass = 0; nfail = 0; ntot = 0;
    cyc = 0; clr_left = 0;
    rst = 1'b1; en = 1'b0; we = '0; addr = '0; din = '0;
    for (int k = 0; k < 3; k++) last[k] = '0;
    tick();
    rst = 1'b0;

    // clear length, with writes attempted while busy
    bc = bsy[0] ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      en = (i < 10); we = 4'hF; addr = 4'd2; din = 32'h12345678;
      tick();
      if (bsy[0]) bc++;
    end
    chk("busy_len", 32'(bc), 32'd16);

    acc_op(1'b0, 4'hF, 4'd2, 32'h0BADF00D);
    for (int a = 0; a < 16; a++) acc_op(1'b1, 4'h0, 4'(a), '0);

    acc_op(1'b1, 4'hF, 4'd3, 32'h11223344);
    acc_op(1'b1, 4'b0101, 4'd3, 32'hAABBCCDD);
    acc_op(1'b1, 4'h0, 4'd3, '0);

    acc_op(1'b1, 4'hF, 4'd5, 32'h0);
    acc_op(1'b1, 4'h0, 4'd3, '0);
    acc_op(1'b1, 4'hF, 4'd5, 32'h55);
    acc_op(1'b0, 4'h0, 4'd0, '0);
    acc_op(1'b1, 4'h0, 4'd5, '0);

    acc_op(1'b1, 4'h0, 4'd0, '0);
    acc_op(1'b1, 4'h0, 4'd1, '0);
    acc_op(1'b1, 4'h0, 4'd2, '0);
    acc_op(1'b0, 4'h0, 4'd0, '0);

    acc_op(1'b1, 4'hF, 4'd7, 32'hCAFEF00D);
    acc_op(1'b1, 4'b0011, 4'd7, 32'h76543210);
    acc_op(1'b1, 4'h0, 4'd7, '0);
    acc_op(1'b0, 4'h0, 4'd0, '0);
    acc_op(1'b0, 4'h0, 4'd0, '0);

    // reset in the middle of a clear restarts it
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bc = bsy[0] ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bsy[0]) bc++;
    end
    chk("busy_len_restart", 32'(bc), 32'd16);

    acc_op(1'b1, 4'h0, 4'd3, '0);
    acc_op(1'b1, 4'h0, 4'd5, '0);
    acc_op(1'b1, 4'h0, 4'd7, '0);
    repeat (3) acc_op(1'b0, 4'h0, 4'd0, '0);

    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d_drained", k), 32'(q[k].size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
